// File: rtl/video_scanlines_pkg.sv
// +----------------------------------------------------------------------------
// | Module  : video_scanlines_pkg
// | Brief   : Shared state encoding, scanline mode constants and step helper.
// | Rev     : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

package video_scanlines_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    RAMP = 2'd2
  } scan_state_t;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_25   = 2'b01;
  localparam logic [1:0] MODE_50   = 2'b10;
  localparam logic [1:0] MODE_75   = 2'b11;

  // Moves one level toward tgt; holds once there.
  function automatic logic [1:0] step_toward(input logic [1:0] cur, input logic [1:0] tgt);
    logic [1:0] res;
    res = cur;
    if (cur < tgt) res = cur + 2'd1;
    else if (cur > tgt) res = cur - 2'd1;
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/video_timing_stable.sv
// +----------------------------------------------------------------------------
// | Module  : video_timing_stable
// | Brief   : Counts lines per frame and flags stable input timing.
// | Rev     : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module video_timing_stable #(
  parameter int STABLE_FRAMES = 2,
  parameter int LINE_W        = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hs_fall,
  input  logic              vs_fall,
  output logic [LINE_W-1:0] lines,
  output logic              stable
);

  localparam int MATCH_W = (STABLE_FRAMES < 1) ? 1 : $clog2(STABLE_FRAMES + 1);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(STABLE_FRAMES);

  logic [LINE_W-1:0]  line_cnt;
  logic [MATCH_W-1:0] match_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_cnt  <= '0;
      lines     <= '0;
      match_cnt <= '0;
    end else if (vs_fall) begin
      // Frame boundary wins over a coincident line edge.
      line_cnt <= '0;
      lines    <= line_cnt;
      if (line_cnt == lines) begin
        if (match_cnt != MATCH_MAX) match_cnt <= match_cnt + 1'b1;
      end else begin
        match_cnt <= '0;
      end
    end else if (hs_fall && (line_cnt != '1)) begin
      line_cnt <= line_cnt + 1'b1;
    end
  end

  assign stable = (match_cnt == MATCH_MAX);

endmodule

`default_nettype wire

// File: rtl/video_scanline_ctrl.sv
// +----------------------------------------------------------------------------
// | Module  : video_scanline_ctrl
// | Brief   : Applies host scanline modes at frame boundaries once timing is stable.
// |           Define SCANLINE_RAMP_EN to step one level per frame toward the target.
// | Rev     : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module video_scanline_ctrl
  import video_scanlines_pkg::*;
#(
  parameter int STABLE_FRAMES = 2,
  parameter int LINE_W        = 11
) (
  input  logic              iPCLK,
  input  logic              iRST,
  input  logic              iCFG_WR,
  input  logic [1:0]        iCFG_DATA,
  input  logic              iHS,
  input  logic              iVS,
  output logic [1:0]        oSCANLINES,
  output logic              oBUSY,
  output logic              oSTABLE,
  output logic [LINE_W-1:0] oLINES
);

  scan_state_t state, state_nxt;
  logic [1:0]  pending, pending_nxt;
  logic [1:0]  target, target_nxt;
  logic [1:0]  current, current_nxt;
  logic        hs_q, vs_q;
  logic        hs_fall, vs_fall;

  assign hs_fall = hs_q & ~iHS;
  assign vs_fall = vs_q & ~iVS;

  video_timing_stable #(
    .STABLE_FRAMES(STABLE_FRAMES),
    .LINE_W       (LINE_W)
  ) u_timing (
    .clk    (iPCLK),
    .rst    (iRST),
    .hs_fall(hs_fall),
    .vs_fall(vs_fall),
    .lines  (oLINES),
    .stable (oSTABLE)
  );

  always_ff @(posedge iPCLK or posedge iRST) begin
    if (iRST) begin
      state      <= IDLE;
      pending    <= MODE_NONE;
      target     <= MODE_NONE;
      current    <= MODE_NONE;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      oSCANLINES <= MODE_NONE;
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      target     <= target_nxt;
      current    <= current_nxt;
      hs_q       <= iHS;
      vs_q       <= iVS;
      // Blank while unstable, but keep target/current so the mode returns.
      oSCANLINES <= oSTABLE ? current : MODE_NONE;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    target_nxt  = target;
    current_nxt = current;
    unique case (state)
      IDLE: ;
      PEND: begin
        if (vs_fall) begin
          target_nxt = pending;
`ifdef SCANLINE_RAMP_EN
          current_nxt = step_toward(current, pending);
          state_nxt   = (current_nxt == pending) ? IDLE : RAMP;
`else
          current_nxt = pending;
          state_nxt   = IDLE;
`endif
        end
      end
      RAMP: begin
        if (vs_fall) begin
          current_nxt = step_toward(current, target);
          if (current_nxt == target) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A write always re-arms PEND, even on the frame edge that just consumed pending.
    if (iCFG_WR) begin
      pending_nxt = iCFG_DATA;
      state_nxt   = PEND;
    end
  end

  assign oBUSY = (state != IDLE);

endmodule

`default_nettype wire
